bcd2binary: RTL and testbench
=============================

Name: bcd2binary

Overview:
- Iterative BCD-to-binary converter using reverse double-dabble: shift right, then subtract 3 from any digit >= 8.
- Companion to the existing binary-to-BCD converter. Turns packed-BCD values (keypad and display-register readback) back into binary for the rx datapath.
- Multi-cycle FSM with a start/done handshake. One conversion in flight at a time.

Parameters:
- BCD_DIGITS, default 4: number of packed BCD digits at the input.
- B_LENGTH, default 14: binary result width. Must satisfy 2^B_LENGTH > 10^BCD_DIGITS - 1.
- BCD_LEN, default 16: input width. Must equal 4*BCD_DIGITS.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- bcd  input  BCD_LEN  packed BCD operand. Digit 0 is bits [3:0]. Sampled only on the accepted start.
- start  input  1  conversion request. Accepted only in IDLE.
- busy  output  1  high from the cycle after start is accepted until DONE exits.
- done  output  1  one-cycle pulse; binary and err are valid in that cycle.
- binary  output  B_LENGTH  converted value. Holds until the next done.
- err  output  1  invalid-digit flag. Updated at each done (see Optional Feature).

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (rst=1 at a clk edge), regardless of state:
  - state goes to IDLE.
  - busy=0, done=0, binary=0, err=0.
  - Internal shift register and counter are cleared.
  - Reset mid-conversion aborts the conversion with no done pulse.
- States are IDLE, SHIFT, ADJUST, DONE (one-hot).
- IDLE:
  - On start=1, load bcd_r<=bcd, bin_r<=0, cnt<=B_LENGTH.
  - Go to SHIFT, or to DONE if the error path applies (Optional Feature).
  - start=0: stay in IDLE.
- SHIFT:
  - {bcd_r,bin_r} <= {bcd_r,bin_r} >> 1 (logical, zero fill at the MSB).
  - cnt <= cnt-1.
  - Go to ADJUST.
- ADJUST:
  - For each digit independently: if digit >= 8, subtract 3 (4-bit, no borrow across digits).
  - If cnt==0, go to DONE; else go to SHIFT.
- DONE:
  - binary <= bin_r, err per the error path, done=1 for exactly this cycle.
  - Next state IDLE.
- Latency (valid operand): start accepted at edge E0; done is high during the cycle after edge E(2*B_LENGTH+1). Defaults give 29 cycles.
- busy is 1 in SHIFT, ADJUST and DONE; 0 in IDLE.
- start while not in IDLE (including the DONE cycle) is ignored, not queued. A start the cycle after done is accepted.
- The bcd input may change freely after acceptance.
- Zero operand runs the full latency and gives binary=0.
- Max operand (all digits 9) gives 10^BCD_DIGITS-1, with no overflow given the parameter rule.

Optional Feature:
- Macro: BCD2BIN_DIGIT_CHECK_EN.
- Defined:
  - In IDLE on accepted start, if any input digit > 9, go directly to DONE.
  - In DONE: err=1, binary=0, done pulses in the cycle after acceptance. Valid operands give err=0.
- Undefined:
  - No digit check; err is tied to 0.
  - Invalid digits run the full latency and the result is unspecified.

Test Plan:
- bcd=16'h1234, start for 1 cycle → done exactly 29 cycles later; binary=14'd1234 (0x04D2), err=0.
- bcd=16'h9999 → binary=14'd9999 (0x270F). bcd=16'h0000 → binary=0, full 29-cycle latency.
- Back-to-back: start h0042, then start again during busy with h0777 → h0777 ignored, binary=42. A new start the cycle after done with h0777 → binary=777.
- With BCD2BIN_DIGIT_CHECK_EN, bcd=16'h12A4 → done 1 cycle after acceptance, err=1, binary=0. Without the macro: err stays 0 and done arrives at 29 cycles.
- rst=1 at cycle 10 of a h5678 conversion → next cycle busy=0, done=0, binary=0, and no done pulse follows. A new start h0005 then gives binary=5.
- Hold start=1 continuously with h0100 → one conversion per 30 cycles (29 latency + IDLE), each done giving binary=100.

Source files
------------

// File: rtl/bcd2binary_if.sv
// bcd2binary_if: start/done handshake bundle for the bcd2binary converter.
//   bcd     packed BCD operand (digit 0 in bits [3:0]), sampled on accepted start
//   start   conversion request
//   busy    conversion in progress
//   done    one-cycle pulse; binary and err valid in that cycle
//   binary  converted value, held until the next done
//   err     invalid-digit flag
// Modports: master drives the request side, slave is the converter.
interface bcd2binary_if #(
  parameter int BCD_LEN  = 16,
  parameter int B_LENGTH = 14
);
  logic [BCD_LEN-1:0]  bcd;
  logic                start;
  logic                busy;
  logic                done;
  logic [B_LENGTH-1:0] binary;
  logic                err;

  modport master (
    output bcd, start,
    input  busy, done, binary, err
  );

  modport slave (
    input  bcd, start,
    output busy, done, binary, err
  );
endinterface

// File: rtl/bcd2binary.sv
// bcd2binary: iterative packed-BCD to binary converter (reverse double-dabble).
// Each bit takes two cycles: SHIFT moves {bcd_r,bin_r} right by one, ADJUST
// subtracts 3 from every BCD digit that is >= 8. After B_LENGTH bit steps the
// binary result sits in bin_r; DONE registers it into binary with a done pulse.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset (aborts a conversion, no done pulse)
//   bus  bcd2binary_if.slave: bcd/start in, busy/done/binary/err out
// Optional build macro BCD2BIN_DIGIT_CHECK_EN: an operand containing a digit
// above 9 skips the iteration, reporting err=1 and binary=0 one cycle after
// acceptance. Without it, err is constant 0 and invalid digits run normally.
module bcd2binary #(
  parameter int BCD_DIGITS = 4,
  parameter int B_LENGTH   = 14,
  parameter int BCD_LEN    = 16
) (
  input logic         clk,
  input logic         rst,
  bcd2binary_if.slave bus
);

  localparam int CNT_W = $clog2(B_LENGTH + 1);

  typedef enum logic [3:0] {
    IDLE   = 4'b0001,
    SHIFT  = 4'b0010,
    ADJUST = 4'b0100,
    DONE   = 4'b1000
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [BCD_LEN-1:0]  bcd_r;
  logic [B_LENGTH-1:0] bin_r;
  logic [B_LENGTH-1:0] binary_r;
  logic [CNT_W-1:0]    cnt;
  logic                done_r;

  // Per-digit correction: digits are independent 4-bit fields, no borrow.
  function automatic logic [BCD_LEN-1:0] adjust_digits(input logic [BCD_LEN-1:0] v);
    logic [BCD_LEN-1:0] r;
    r = v;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (v[4*i +: 4] >= 4'd8) r[4*i +: 4] = v[4*i +: 4] - 4'd3;
    end
    return r;
  endfunction

`ifdef BCD2BIN_DIGIT_CHECK_EN
  logic bad_r;
  logic err_r;

  function automatic logic digits_invalid(input logic [BCD_LEN-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
`ifdef BCD2BIN_DIGIT_CHECK_EN
          state_nxt = digits_invalid(bus.bcd) ? DONE : SHIFT;
`else
          state_nxt = SHIFT;
`endif
        end
      end
      SHIFT:  state_nxt = ADJUST;
      ADJUST: state_nxt = (cnt == '0) ? DONE : SHIFT;
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_r    <= '0;
      bin_r    <= '0;
      cnt      <= '0;
      binary_r <= '0;
      done_r   <= 1'b0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
      bad_r    <= 1'b0;
      err_r    <= 1'b0;
`endif
    end else begin
      done_r <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            bcd_r <= bus.bcd;
            bin_r <= '0;
            cnt   <= CNT_W'(B_LENGTH);
`ifdef BCD2BIN_DIGIT_CHECK_EN
            bad_r <= digits_invalid(bus.bcd);
`endif
          end
        end
        SHIFT: begin
          // Logical right shift across the concatenation, zero into the BCD MSB.
          {bcd_r, bin_r} <= {1'b0, bcd_r, bin_r[B_LENGTH-1:1]};
          cnt            <= cnt - CNT_W'(1);
        end
        ADJUST: bcd_r <= adjust_digits(bcd_r);
        DONE: begin
          // On the error path bin_r was cleared at acceptance and never shifted.
          binary_r <= bin_r;
          done_r   <= 1'b1;
`ifdef BCD2BIN_DIGIT_CHECK_EN
          err_r    <= bad_r;
`endif
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = (state != IDLE);
  assign bus.done   = done_r;
  assign bus.binary = binary_r;
`ifdef BCD2BIN_DIGIT_CHECK_EN
  assign bus.err    = err_r;
`else
  assign bus.err    = 1'b0;
`endif

endmodule

// File: tb/tb_bcd2binary.sv
// tb_bcd2binary: self-checking bench for bcd2binary.
// Table vectors with hand-written expected results, hand sequences for
// back-to-back starts, mid-conversion reset and held start, then random
// operands checked against a decimal-arithmetic reference model.
module tb_bcd2binary;
  localparam int BCD_DIGITS = 4;
  localparam int B_LENGTH   = 14;
  localparam int BCD_LEN    = 16;
  localparam int LAT        = 2 * B_LENGTH + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bcd2binary_if #(.BCD_LEN(BCD_LEN), .B_LENGTH(B_LENGTH)) bus ();

  bcd2binary #(
    .BCD_DIGITS(BCD_DIGITS),
    .B_LENGTH  (B_LENGTH),
    .BCD_LEN   (BCD_LEN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int t0       = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [BCD_LEN-1:0] bcd;
    int                 bin;
    int                 lat;
    bit                 err;
    bit                 chk_bin;
  } vec_t;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference model: decimal value of the digit string.
  function automatic int bcd_value(input logic [BCD_LEN-1:0] v);
    int acc;
    acc = 0;
    for (int i = BCD_DIGITS - 1; i >= 0; i--) acc = acc * 10 + int'(v[4*i +: 4]);
    return acc;
  endfunction

  function automatic bit has_bad(input logic [BCD_LEN-1:0] v);
    bit b;
    b = 1'b0;
    for (int i = 0; i < BCD_DIGITS; i++) if (v[4*i +: 4] > 4'd9) b = 1'b1;
    return b;
  endfunction

  // Expected outcome derived from the operand by the model.
  function automatic vec_t model(input logic [BCD_LEN-1:0] v);
    vec_t e;
    e.bcd = v;
    e.bin = bcd_value(v);
    e.lat = LAT;
    e.err = 1'b0;
    e.chk_bin = 1'b1;
    if (has_bad(v)) begin
`ifdef BCD2BIN_DIGIT_CHECK_EN
      e.bin = 0;
      e.lat = 1;
      e.err = 1'b1;
`else
      e.chk_bin = 1'b0;
`endif
    end
    return e;
  endfunction

  // Present operand with start for one edge (acceptance edge E0).
  task automatic start_op(input logic [BCD_LEN-1:0] v);
    @(negedge clk);
    bus.bcd   = v;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    t0        = cyc;
    bus.start = 1'b0;
    bus.bcd   = BCD_LEN'($urandom);
  endtask

  task automatic wait_done(input string name, output int lat);
    lat = -1;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = cyc - t0;
        break;
      end
    end
    if (lat < 0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no_done required=done_within_200", name);
    end
  endtask

  task automatic run_vec(input string name, input vec_t v);
    int lat;
    start_op(v.bcd);
    check({name, "_busy_start"}, int'(bus.busy), 1);
    wait_done(name, lat);
    if (lat >= 0) begin
      check({name, "_latency"}, lat, v.lat);
      check({name, "_err"}, int'(bus.err), int'(v.err));
      check({name, "_busy_done"}, int'(bus.busy), 0);
      if (v.chk_bin) check({name, "_binary"}, int'(bus.binary), v.bin);
    end
  endtask

  vec_t vecs[9];

  initial begin
    int lat;
    int ndone;
    int last;
    logic [BCD_LEN-1:0] r;

    vecs[0] = '{16'h1234, 1234, LAT, 1'b0, 1'b1};
    vecs[1] = '{16'h9999, 9999, LAT, 1'b0, 1'b1};
    vecs[2] = '{16'h0000, 0,    LAT, 1'b0, 1'b1};
    vecs[3] = '{16'h0001, 1,    LAT, 1'b0, 1'b1};
    vecs[4] = '{16'h0042, 42,   LAT, 1'b0, 1'b1};
    vecs[5] = '{16'h0800, 800,  LAT, 1'b0, 1'b1};
    vecs[6] = '{16'h9000, 9000, LAT, 1'b0, 1'b1};
    vecs[7] = '{16'h0909, 909,  LAT, 1'b0, 1'b1};
`ifdef BCD2BIN_DIGIT_CHECK_EN
    vecs[8] = '{16'h12A4, 0,    1,   1'b1, 1'b1};
`else
    vecs[8] = '{16'h12A4, 0,    LAT, 1'b0, 1'b0};
`endif

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.bcd   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy",   int'(bus.busy),   0);
    check("reset_done",   int'(bus.done),   0);
    check("reset_binary", int'(bus.binary), 0);
    check("reset_err",    int'(bus.err),    0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Start during busy is ignored and not queued.
    start_op(16'h0042);
    repeat (5) @(posedge clk);
    @(negedge clk);
    bus.bcd   = 16'h0777;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done("b2b_first", lat);
    check("b2b_first_latency", lat, LAT);
    check("b2b_first_binary", int'(bus.binary), 42);
    ndone = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      if (bus.done) ndone++;
    end
    check("b2b_ignored_no_done", ndone, 0);

    // New start in the cycle after done is accepted.
    start_op(16'h0042);
    wait_done("b2b_again", lat);
    check("b2b_again_binary", int'(bus.binary), 42);
    run_vec("b2b_next", '{16'h0777, 777, LAT, 1'b0, 1'b1});

    // Held start: one conversion every LAT+1 cycles.
    @(negedge clk);
    bus.bcd   = 16'h0100;
    bus.start = 1'b1;
    ndone = 0;
    last  = -1;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        check("hold_binary", int'(bus.binary), 100);
        if (last >= 0) check("hold_period", cyc - last, LAT + 1);
        last = cyc;
        ndone++;
      end
    end
    bus.start = 1'b0;
    check("hold_count", ndone, 3);
    repeat (40) @(posedge clk);
    #1;

    // Reset mid-conversion aborts without a done pulse.
    start_op(16'h5678);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_busy",   int'(bus.busy),   0);
    check("midrst_done",   int'(bus.done),   0);
    check("midrst_binary", int'(bus.binary), 0);
    ndone = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      if (bus.done) ndone++;
    end
    check("midrst_no_done", ndone, 0);
    run_vec("after_rst", '{16'h0005, 5, LAT, 1'b0, 1'b1});

    // Random operands, occasionally with an invalid digit.
    for (int k = 0; k < 40; k++) begin
      for (int d = 0; d < BCD_DIGITS; d++) begin
        if ($urandom_range(0, 7) == 0) r[4*d +: 4] = 4'($urandom_range(10, 15));
        else                           r[4*d +: 4] = 4'($urandom_range(0, 9));
      end
      run_vec($sformatf("rand%0d_%h", k, r), model(r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=still_running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
